// File: rtl/parking_sound_pkg.sv
// ---------------------------------------------------------------------------
// parking_sound_pkg
// Shared types and constants for the parking-sensor audio path:
//   zone_t        3-bit proximity zone (0 = nothing in range, 7 = critical)
//   KEY_RELEASE   key code meaning release/silence at the tone generator
//   beep_state_t  beep scheduler states
//   off_ms()      silent-gap length in ms for zones 1..6
// ---------------------------------------------------------------------------
package parking_sound_pkg;

  typedef logic [2:0] zone_t;

  localparam zone_t ZONE_NONE = 3'd0;
  localparam zone_t ZONE_CRIT = 3'd7;

  localparam logic [7:0] KEY_RELEASE = 8'hf0;

  // Width and saturation value of the millisecond counter
  localparam int unsigned     MS_W   = 12;
  localparam logic [MS_W-1:0] MS_MAX = 12'hfff;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BEEP_ON  = 2'd1,
    BEEP_OFF = 2'd2,
    CONT     = 2'd3
  } beep_state_t;

  // Gap between beeps; closer zones give shorter gaps. Zones 0 and 7 never
  // reach the gap comparison, so they map to the longest possible value.
  function automatic logic [MS_W-1:0] off_ms(input zone_t zone);
    logic [MS_W-1:0] w_ms;
    case (zone)
      3'd1:    w_ms = 12'd800;
      3'd2:    w_ms = 12'd500;
      3'd3:    w_ms = 12'd300;
      3'd4:    w_ms = 12'd180;
      3'd5:    w_ms = 12'd100;
      3'd6:    w_ms = 12'd60;
      default: w_ms = MS_MAX;
    endcase
    return w_ms;
  endfunction

endpackage

// File: rtl/ms_timebase.sv
// ---------------------------------------------------------------------------
// ms_timebase
// Prescaler producing a one-cycle tick every TICK_DIV clocks, and a
// saturating millisecond counter advanced by that tick.
// Ports:
//   i_clk     system clock
//   i_rst_n   synchronous active-low reset
//   i_clr     synchronous clear of prescaler and ms counter
//   o_tick    high in the last prescaler cycle of each millisecond
//   o_ms_cnt  completed milliseconds since the last clear (saturates)
// ---------------------------------------------------------------------------
module ms_timebase
  import parking_sound_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clr,
  output logic            o_tick,
  output logic [MS_W-1:0] o_ms_cnt
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]   r_presc;
  logic [MS_W-1:0] r_ms_cnt;
  logic            w_tick;

  assign w_tick   = (r_presc == PRESC_LAST);
  assign o_tick   = w_tick;
  assign o_ms_cnt = r_ms_cnt;

  // Prescaler and millisecond counter; clear wins over counting
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_presc  <= PW'(1'b0);
      r_ms_cnt <= 12'd0;
    end else if (i_clr) begin
      r_presc  <= PW'(1'b0);
      r_ms_cnt <= 12'd0;
    end else if (w_tick) begin
      r_presc <= PW'(1'b0);
      if (r_ms_cnt != MS_MAX) begin
        r_ms_cnt <= r_ms_cnt + 12'd1;
      end else begin
        r_ms_cnt <= r_ms_cnt;
      end
    end else begin
      r_presc <= r_presc + PW'(1'b1);
    end
  end

endmodule

// File: rtl/beep_scheduler.sv
// ---------------------------------------------------------------------------
// beep_scheduler
// Turns the proximity zone into timed key_code beep patterns for the tone
// generator: faster cadence as the obstacle gets closer, continuous critical
// tone in zone 7, silence when nothing is in range or when muted.
// Ports:
//   clock     system clock (posedge)
//   k_tr      synchronous active-low reset
//   zone_in   proximity zone, 0 = none, 1..6 = far..near, 7 = critical
//   mute      level, 1 forces silence (used unregistered)
//   key_code  NOTE_CODE while beeping, CRIT_CODE in critical, 8'hf0 otherwise
//   beeping   high while a tone is sounding
//   beep_cnt  number of beep starts, wraps 255 -> 0
// ---------------------------------------------------------------------------
module beep_scheduler
  import parking_sound_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned ON_MS     = 60,
  parameter logic [7:0]  NOTE_CODE = 8'h2b,
  parameter logic [7:0]  CRIT_CODE = 8'h52
) (
  input  logic       clock,
  input  logic       k_tr,
  input  logic [2:0] zone_in,
  input  logic       mute,
  output logic [7:0] key_code,
  output logic       beeping,
  output logic [7:0] beep_cnt
);

  localparam logic [MS_W-1:0] ON_LIMIT = MS_W'(ON_MS);

  zone_t           r_zone_q;
  beep_state_t     r_state;
  beep_state_t     w_state_nxt;
  logic [7:0]      r_key_code;
  logic            r_beeping;
  logic [7:0]      r_beep_cnt;

  logic            w_tick;
  logic [MS_W-1:0] w_ms_cnt;
  logic [MS_W-1:0] w_elapsed;
  logic            w_stop;
  logic            w_crit;
  logic            w_clr;

  // Every state change restarts the timebase so each state is timed from 0
  assign w_clr = (w_state_nxt != r_state);

  ms_timebase #(
    .TICK_DIV (TICK_DIV)
  ) u_timebase (
    .i_clk    (clock),
    .i_rst_n  (k_tr),
    .i_clr    (w_clr),
    .o_tick   (w_tick),
    .o_ms_cnt (w_ms_cnt)
  );

  // Milliseconds completed at the end of this cycle. Comparing against this
  // rather than the raw count makes a state held N ms last N*TICK_DIV cycles.
  assign w_elapsed = (w_tick && (w_ms_cnt != MS_MAX)) ? (w_ms_cnt + 12'd1) : w_ms_cnt;

  assign w_stop = (r_zone_q == ZONE_NONE) || mute;
  assign w_crit = (r_zone_q == ZONE_CRIT);

  // Zone input register
  always_ff @(posedge clock) begin
    if (!k_tr) begin
      r_zone_q <= ZONE_NONE;
    end else begin
      r_zone_q <= zone_in;
    end
  end

  // Next-state selection; stop outranks critical, which outranks timer expiry
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_stop) begin
          w_state_nxt = IDLE;
        end else if (w_crit) begin
          w_state_nxt = CONT;
        end else begin
          w_state_nxt = BEEP_ON;
        end
      end
      BEEP_ON: begin
        if (w_stop) begin
          w_state_nxt = IDLE;
        end else if (w_crit) begin
          w_state_nxt = CONT;
        end else if (w_tick && (w_elapsed == ON_LIMIT)) begin
          w_state_nxt = BEEP_OFF;
        end else begin
          w_state_nxt = BEEP_ON;
        end
      end
      BEEP_OFF: begin
        // Live zone: moving closer shortens the gap already in progress
        if (w_stop) begin
          w_state_nxt = IDLE;
        end else if (w_crit) begin
          w_state_nxt = CONT;
        end else if (w_elapsed >= off_ms(r_zone_q)) begin
          w_state_nxt = BEEP_ON;
        end else begin
          w_state_nxt = BEEP_OFF;
        end
      end
      CONT: begin
        // Leaving critical always goes through a full gap first
        if (w_stop) begin
          w_state_nxt = IDLE;
        end else if (!w_crit) begin
          w_state_nxt = BEEP_OFF;
        end else begin
          w_state_nxt = CONT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register with outputs registered from the next state, so they
  // always equal the decode of the current state
  always_ff @(posedge clock) begin
    if (!k_tr) begin
      r_state    <= IDLE;
      r_key_code <= KEY_RELEASE;
      r_beeping  <= 1'b0;
      r_beep_cnt <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      case (w_state_nxt)
        BEEP_ON: begin
          r_key_code <= NOTE_CODE;
          r_beeping  <= 1'b1;
        end
        CONT: begin
          r_key_code <= CRIT_CODE;
          r_beeping  <= 1'b1;
        end
        default: begin
          r_key_code <= KEY_RELEASE;
          r_beeping  <= 1'b0;
        end
      endcase
      if ((w_state_nxt == BEEP_ON) && (r_state != BEEP_ON)) begin
        r_beep_cnt <= r_beep_cnt + 8'd1;
      end else begin
        r_beep_cnt <= r_beep_cnt;
      end
    end
  end

  assign key_code = r_key_code;
  assign beeping  = r_beeping;
  assign beep_cnt = r_beep_cnt;

endmodule

// File: tb/tb_beep_scheduler.sv
// ---------------------------------------------------------------------------
// tb_beep_scheduler
// Self-checking bench for beep_scheduler with TICK_DIV=4, ON_MS=3.
// A monitor records every constant-key_code segment (code, length in cycles,
// beep_cnt at its start). Each test pushes the segments it expects to a
// scoreboard queue and compares them as the monitor reports them, plus
// inline point checks at known cycles.
// ---------------------------------------------------------------------------
module tb_beep_scheduler;

  localparam int OBS_N = 1024;

  typedef struct {
    logic [7:0] code;
    int         len;   // 0 = length not checked
    int         cnt;   // -1 = beep_cnt not checked
  } seg_t;

  logic       clk;
  logic       k_tr;
  logic [2:0] zone_in;
  logic       mute;
  logic [7:0] key_code;
  logic       beeping;
  logic [7:0] beep_cnt;

  int   n_cmp;
  int   n_fail;
  seg_t exp_q[$];

  // monitor state
  logic       mon_en;
  logic [7:0] mon_prev;
  bit         mon_run;
  int         mon_len;
  int         mon_cnt;
  logic [7:0] obs_code [OBS_N];
  int         obs_len  [OBS_N];
  int         obs_cnt  [OBS_N];
  int         obs_wr;

  beep_scheduler #(
    .TICK_DIV  (4),
    .ON_MS     (3),
    .NOTE_CODE (8'h2b),
    .CRIT_CODE (8'h52)
  ) dut (
    .clock    (clk),
    .k_tr     (k_tr),
    .zone_in  (zone_in),
    .mute     (mute),
    .key_code (key_code),
    .beeping  (beeping),
    .beep_cnt (beep_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    obs_wr  = 0;
    mon_run = 1'b0;
    mon_len = 0;
    mon_cnt = 0;
  end

  // Segment monitor: a finished segment is recorded when key_code changes
  always @(negedge clk) begin
    if (!mon_en) begin
      mon_run  = 1'b0;
      mon_prev = key_code;
    end else if (key_code !== mon_prev) begin
      if (mon_run) begin
        obs_code[obs_wr % OBS_N] = mon_prev;
        obs_len[obs_wr % OBS_N]  = mon_len;
        obs_cnt[obs_wr % OBS_N]  = mon_cnt;
        obs_wr = obs_wr + 1;
      end
      mon_run  = 1'b1;
      mon_len  = 1;
      mon_prev = key_code;
      mon_cnt  = int'(beep_cnt);
    end else begin
      mon_len = mon_len + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_seg(input logic [7:0] code, input int len, input int cnt);
    seg_t s;
    s.code = code;
    s.len  = len;
    s.cnt  = cnt;
    exp_q.push_back(s);
  endtask

  task automatic wait_segs(input int rd, input int n, input int bound);
    for (int c = 0; c < bound; c++) begin
      if (obs_wr - rd >= n) break;
      @(negedge clk);
    end
  endtask

  // Hold reset two cycles with zone z, arm the monitor, release reset.
  // Returns at E0+1; the first non-reset edge is E1, BEEP_ON/CONT at E2.
  task automatic start_run(input logic [2:0] z, output int rd);
    k_tr    = 1'b0;
    zone_in = z;
    mute    = 1'b0;
    mon_en  = 1'b0;
    tick(2);
    rd     = obs_wr;
    mon_en = 1'b1;
    k_tr   = 1'b1;
  endtask

  task automatic test_reset();
    int   rd;
    int   k;
    seg_t e;
    k_tr = 1'b0; zone_in = 3'd5; mute = 1'b0;
    tick(3);
    n_cmp++; if (key_code !== 8'hf0) begin n_fail++; $display("FAIL reset_key: got %h need f0", key_code); end
    n_cmp++; if (beeping !== 1'b0) begin n_fail++; $display("FAIL reset_beeping: got %b need 0", beeping); end
    n_cmp++; if (beep_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d need 0", beep_cnt); end
    start_run(3'd5, rd);
    tick(1);
    n_cmp++; if (key_code !== 8'hf0) begin n_fail++; $display("FAIL reset_rel1: got %h need f0", key_code); end
    tick(1);
    n_cmp++; if (key_code !== 8'h2b) begin n_fail++; $display("FAIL reset_rel2_key: got %h need 2b", key_code); end
    n_cmp++; if (beeping !== 1'b1) begin n_fail++; $display("FAIL reset_rel2_beeping: got %b need 1", beeping); end
    n_cmp++; if (beep_cnt !== 8'd1) begin n_fail++; $display("FAIL reset_rel2_cnt: got %0d need 1", beep_cnt); end
    exp_seg(8'h2b, 12, 1); exp_seg(8'hf0, 400, -1);
    exp_seg(8'h2b, 12, 2); exp_seg(8'hf0, 400, -1);
    wait_segs(rd, exp_q.size(), 3000);
    n_cmp++;
    if (obs_wr - rd < exp_q.size()) begin
      n_fail++; $display("FAIL reset_seg_count: got %0d segments need %0d", obs_wr - rd, exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && rd < obs_wr; i++) begin
      e = exp_q.pop_front(); k = rd % OBS_N; rd++;
      n_cmp++;
      if (obs_code[k] !== e.code || (e.len != 0 && obs_len[k] != e.len) || (e.cnt >= 0 && obs_cnt[k] != e.cnt)) begin
        n_fail++;
        $display("FAIL reset_seg%0d: got code %h len %0d cnt %0d need code %h len %0d cnt %0d", i, obs_code[k], obs_len[k], obs_cnt[k], e.code, e.len, e.cnt);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_zone_change();
    int   rd;
    int   k;
    seg_t e;
    start_run(3'd1, rd);
    tick(14);   // E14+1: gap just started
    n_cmp++; if (key_code !== 8'hf0) begin n_fail++; $display("FAIL zone_gap_start: got %h need f0", key_code); end
    tick(400);  // E414+1: ms_cnt = 100, zone 1 gap still running
    n_cmp++; if (key_code !== 8'hf0) begin n_fail++; $display("FAIL zone_gap_mid: got %h need f0", key_code); end
    zone_in = 3'd6;
    tick(2);
    n_cmp++; if (key_code !== 8'h2b) begin n_fail++; $display("FAIL zone_new_beep: got %h need 2b", key_code); end
    n_cmp++; if (beep_cnt !== 8'd2) begin n_fail++; $display("FAIL zone_new_cnt: got %0d need 2", beep_cnt); end
    exp_seg(8'h2b, 12, 1); exp_seg(8'hf0, 402, -1);
    exp_seg(8'h2b, 12, 2); exp_seg(8'hf0, 240, -1);
    wait_segs(rd, exp_q.size(), 2000);
    n_cmp++;
    if (obs_wr - rd < exp_q.size()) begin
      n_fail++; $display("FAIL zone_seg_count: got %0d segments need %0d", obs_wr - rd, exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && rd < obs_wr; i++) begin
      e = exp_q.pop_front(); k = rd % OBS_N; rd++;
      n_cmp++;
      if (obs_code[k] !== e.code || (e.len != 0 && obs_len[k] != e.len) || (e.cnt >= 0 && obs_cnt[k] != e.cnt)) begin
        n_fail++;
        $display("FAIL zone_seg%0d: got code %h len %0d cnt %0d need code %h len %0d cnt %0d", i, obs_code[k], obs_len[k], obs_cnt[k], e.code, e.len, e.cnt);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_critical();
    int   rd;
    int   k;
    seg_t e;
    start_run(3'd3, rd);
    tick(7);    // E7+1, mid-beep
    zone_in = 3'd7;
    tick(2);    // E9+1
    n_cmp++; if (key_code !== 8'h52) begin n_fail++; $display("FAIL crit_enter: got %h need 52", key_code); end
    n_cmp++; if (beeping !== 1'b1) begin n_fail++; $display("FAIL crit_beeping: got %b need 1", beeping); end
    tick(50);   // E59+1
    n_cmp++; if (key_code !== 8'h52) begin n_fail++; $display("FAIL crit_hold: got %h need 52", key_code); end
    n_cmp++; if (beep_cnt !== 8'd1) begin n_fail++; $display("FAIL crit_cnt: got %0d need 1", beep_cnt); end
    zone_in = 3'd3;
    tick(2);    // E61+1
    n_cmp++; if (beeping !== 1'b0) begin n_fail++; $display("FAIL crit_exit: got %b need 0", beeping); end
    exp_seg(8'h2b, 7, 1); exp_seg(8'h52, 52, 1);
    exp_seg(8'hf0, 1200, -1); exp_seg(8'h2b, 12, 2);
    wait_segs(rd, exp_q.size(), 3000);
    n_cmp++;
    if (obs_wr - rd < exp_q.size()) begin
      n_fail++; $display("FAIL crit_seg_count: got %0d segments need %0d", obs_wr - rd, exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && rd < obs_wr; i++) begin
      e = exp_q.pop_front(); k = rd % OBS_N; rd++;
      n_cmp++;
      if (obs_code[k] !== e.code || (e.len != 0 && obs_len[k] != e.len) || (e.cnt >= 0 && obs_cnt[k] != e.cnt)) begin
        n_fail++;
        $display("FAIL crit_seg%0d: got code %h len %0d cnt %0d need code %h len %0d cnt %0d", i, obs_code[k], obs_len[k], obs_cnt[k], e.code, e.len, e.cnt);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_mute();
    int   rd;
    int   k;
    seg_t e;
    start_run(3'd4, rd);
    tick(6);    // E6+1
    mute = 1'b1;
    tick(1);    // E7+1
    n_cmp++; if (key_code !== 8'hf0) begin n_fail++; $display("FAIL mute_silent: got %h need f0", key_code); end
    n_cmp++; if (beeping !== 1'b0) begin n_fail++; $display("FAIL mute_beeping: got %b need 0", beeping); end
    mute = 1'b0;
    tick(1);    // E8+1
    n_cmp++; if (key_code !== 8'h2b) begin n_fail++; $display("FAIL mute_restart: got %h need 2b", key_code); end
    n_cmp++; if (beep_cnt !== 8'd2) begin n_fail++; $display("FAIL mute_cnt: got %0d need 2", beep_cnt); end
    exp_seg(8'h2b, 5, 1); exp_seg(8'hf0, 1, -1); exp_seg(8'h2b, 12, 2);
    wait_segs(rd, exp_q.size(), 200);
    n_cmp++;
    if (obs_wr - rd < exp_q.size()) begin
      n_fail++; $display("FAIL mute_seg_count: got %0d segments need %0d", obs_wr - rd, exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && rd < obs_wr; i++) begin
      e = exp_q.pop_front(); k = rd % OBS_N; rd++;
      n_cmp++;
      if (obs_code[k] !== e.code || (e.len != 0 && obs_len[k] != e.len) || (e.cnt >= 0 && obs_cnt[k] != e.cnt)) begin
        n_fail++;
        $display("FAIL mute_seg%0d: got code %h len %0d cnt %0d need code %h len %0d cnt %0d", i, obs_code[k], obs_len[k], obs_cnt[k], e.code, e.len, e.cnt);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_in_cont();
    int   rd;
    int   k;
    seg_t e;
    start_run(3'd2, rd);
    tick(5);    // E5+1
    zone_in = 3'd7;
    tick(2);    // E7+1
    n_cmp++; if (key_code !== 8'h52) begin n_fail++; $display("FAIL rcont_crit: got %h need 52", key_code); end
    tick(10);   // E17+1
    k_tr = 1'b0;
    tick(1);    // E18+1
    n_cmp++; if (key_code !== 8'hf0) begin n_fail++; $display("FAIL rcont_key: got %h need f0", key_code); end
    n_cmp++; if (beep_cnt !== 8'd0) begin n_fail++; $display("FAIL rcont_cnt: got %0d need 0", beep_cnt); end
    n_cmp++; if (beeping !== 1'b0) begin n_fail++; $display("FAIL rcont_beeping: got %b need 0", beeping); end
    k_tr = 1'b1;
    tick(1);    // E19+1
    n_cmp++; if (key_code !== 8'hf0) begin n_fail++; $display("FAIL rcont_rel1: got %h need f0", key_code); end
    tick(1);    // E20+1
    n_cmp++; if (key_code !== 8'h52) begin n_fail++; $display("FAIL rcont_rel2: got %h need 52", key_code); end
    n_cmp++; if (beep_cnt !== 8'd0) begin n_fail++; $display("FAIL rcont_cont_cnt: got %0d need 0", beep_cnt); end
    exp_seg(8'h2b, 5, 1); exp_seg(8'h52, 11, 1); exp_seg(8'hf0, 2, 0);
    wait_segs(rd, exp_q.size(), 200);
    n_cmp++;
    if (obs_wr - rd < exp_q.size()) begin
      n_fail++; $display("FAIL rcont_seg_count: got %0d segments need %0d", obs_wr - rd, exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && rd < obs_wr; i++) begin
      e = exp_q.pop_front(); k = rd % OBS_N; rd++;
      n_cmp++;
      if (obs_code[k] !== e.code || (e.len != 0 && obs_len[k] != e.len) || (e.cnt >= 0 && obs_cnt[k] != e.cnt)) begin
        n_fail++;
        $display("FAIL rcont_seg%0d: got code %h len %0d cnt %0d need code %h len %0d cnt %0d", i, obs_code[k], obs_len[k], obs_cnt[k], e.code, e.len, e.cnt);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    int   rd;
    int   k;
    seg_t e;
    start_run(3'd6, rd);
    for (int b = 1; b <= 256; b++) begin
      exp_seg(8'h2b, 12, b % 256);
      exp_seg(8'hf0, 240, -1);
    end
    wait_segs(rd, exp_q.size(), 70000);
    n_cmp++;
    if (obs_wr - rd < exp_q.size()) begin
      n_fail++; $display("FAIL wrap_seg_count: got %0d segments need %0d", obs_wr - rd, exp_q.size());
    end
    n_cmp++; if (beep_cnt !== 8'd1) begin n_fail++; $display("FAIL wrap_after: got %0d need 1", beep_cnt); end
    for (int i = 0; exp_q.size() > 0 && rd < obs_wr; i++) begin
      e = exp_q.pop_front(); k = rd % OBS_N; rd++;
      n_cmp++;
      if (obs_code[k] !== e.code || (e.len != 0 && obs_len[k] != e.len) || (e.cnt >= 0 && obs_cnt[k] != e.cnt)) begin
        n_fail++;
        $display("FAIL wrap_seg%0d: got code %h len %0d cnt %0d need code %h len %0d cnt %0d", i, obs_code[k], obs_len[k], obs_cnt[k], e.code, e.len, e.cnt);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    k_tr    = 1'b0;
    zone_in = 3'd0;
    mute    = 1'b0;
    test_reset();
    test_zone_change();
    test_critical();
    test_mute();
    test_reset_in_cont();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
